txarb: RTL

Frame-granular round-robin arbiter that shares the single serial-send byte interface between up to NREQ frame generators. Example generators: the sensor-data reply generator and a status/heartbeat generator. Once a requester is granted, it owns the bus for one whole frame, byte by byte. The arbiter forwards that requester's bytes and routes the send-complete pulse back to it only. It sits between the frame generators and the serial-send module.

---
 rtl/txarb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/txarb.sv
// Frame-granular round-robin arbiter sharing one serial-send byte interface among NREQ requesters.
// Optional idle-grant timeout is built only when TXARB_TIMEOUT_EN is defined.
module txarb #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]     req_data_flag,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     req_send_finish,
   output logic [7:0]          bus_data,
   output logic                bus_data_flag,
   input  logic                bus_send_finish,
   output logic                busy,
   output logic                tmo
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_SEND,
      S_RELEASE
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   gidx, gidx_nxt;
   logic [IW-1:0]   last_gnt, last_gnt_nxt;
   logic            last_r, last_r_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [NREQ-1:0] req_send_finish_nxt;
   logic [7:0]      bus_data_nxt;
   logic            bus_data_flag_nxt;
   logic            busy_nxt;

   logic [7:0]      req_byte [NREQ];
   logic [IW-1:0]   pick_c;
   logic            pick_vld_c;
   logic            expire_c;

   // Unpack the per-requester byte lanes
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_byte[i] = req_data[8*i +: 8];
      end
   end

   // Round-robin search from last_gnt+1; descending scan so the nearest offset wins
   always_comb begin
      int unsigned idx;
      pick_c     = '0;
      pick_vld_c = 1'b0;
      idx        = 0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         idx = (32'(last_gnt) + k) % NREQ;
         if (req[IW'(idx)]) begin
            pick_c     = IW'(idx);
            pick_vld_c = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state           <= S_IDLE;
         gidx            <= '0;
         last_gnt        <= IW'(NREQ - 1);
         last_r          <= 1'b0;
         gnt             <= '0;
         req_send_finish <= '0;
         bus_data        <= 8'h00;
         bus_data_flag   <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state           <= state_nxt;
         gidx            <= gidx_nxt;
         last_gnt        <= last_gnt_nxt;
         last_r          <= last_r_nxt;
         gnt             <= gnt_nxt;
         req_send_finish <= req_send_finish_nxt;
         bus_data        <= bus_data_nxt;
         bus_data_flag   <= bus_data_flag_nxt;
         busy            <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt           = state;
      gidx_nxt            = gidx;
      last_gnt_nxt        = last_gnt;
      last_r_nxt          = last_r;
      gnt_nxt             = gnt;
      req_send_finish_nxt = '0;
      bus_data_nxt        = bus_data;
      bus_data_flag_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (pick_vld_c) begin
               gidx_nxt  = pick_c;
               gnt_nxt   = NREQ'(1) << pick_c;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            // Only the owner's flag is honoured; finish pulses here are stray
            if (req_data_flag[gidx]) begin
               bus_data_nxt      = req_byte[gidx];
               bus_data_flag_nxt = 1'b1;
               last_r_nxt        = req_last[gidx];
               state_nxt         = S_SEND;
            end else if (expire_c) begin
               gnt_nxt      = '0;
               last_gnt_nxt = gidx;
               state_nxt    = S_RELEASE;
            end
         end
         S_SEND: begin
            if (bus_send_finish) begin
               req_send_finish_nxt = NREQ'(1) << gidx;
               if (last_r) begin
                  gnt_nxt      = '0;
                  last_gnt_nxt = gidx;
                  state_nxt    = S_RELEASE;
               end else begin
                  state_nxt = S_GRANT;
               end
            end
         end
         S_RELEASE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

`ifdef TXARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] idle_cnt;

   assign expire_c = (idle_cnt == CW'(TIMEOUT - 1));

   // Counts silent GRANT cycles; held at zero outside GRANT so every entry starts fresh
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         idle_cnt <= '0;
         tmo      <= 1'b0;
      end else begin
         tmo <= (state == S_GRANT) && !req_data_flag[gidx] && expire_c;
         if (state != S_GRANT) begin
            idle_cnt <= '0;
         end else if (!req_data_flag[gidx]) begin
            idle_cnt <= idle_cnt + CW'(1);
         end
      end
   end
`else
   assign expire_c = 1'b0;
   assign tmo      = 1'b0;
`endif

endmodule
